// File: rtl/hbm_pkg.sv
// Shared widths, word-offset constant and responder state type for the HBM responder.
package hbm_pkg;
    localparam int HBM_DATA_WIDTH = 512;
    localparam int HBM_ADDR_WIDTH = 32;
    localparam int HBM_WORD_LSB   = 6;

    typedef enum logic {
        ACTIVE  = 1'b0,
        REFRESH = 1'b1
    } hbm_resp_state_t;
endpackage

// File: rtl/hbm_rd_pipe.sv
// Fixed-latency read return pipe carrying valid, data and error flags.
// Data is zeroed on non-valid stages so the output idles at 0.
module hbm_rd_pipe #(
    parameter int DATA_WIDTH = 512,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_err,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err
);
    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] err_q;
    logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            err_q[0] <= in_valid && in_err;
            dat_q[0] <= (in_valid && !in_err) ? in_data : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[RD_LATENCY-1];
    assign out_err   = err_q[RD_LATENCY-1];
    assign out_data  = dat_q[RD_LATENCY-1];
endmodule

// File: rtl/hbm_responder.sv
// HBM-style memory responder: word storage, fixed-latency reads, range checking.
// Periodic refresh stalls are built in only when HBM_RESP_REFRESH_EN is defined.
//
// state   | meaning
// ACTIVE  | accepting requests, refresh_cnt counting toward the next refresh
// REFRESH | requests blocked for REFRESH_CYCLES cycles; in-flight reads still return
module hbm_responder
    import hbm_pkg::*;
#(
    parameter int DATA_WIDTH     = HBM_DATA_WIDTH,
    parameter int ADDR_WIDTH     = HBM_ADDR_WIDTH,
    parameter int DEPTH_WORDS    = 256,
    parameter int RD_LATENCY     = 2,
    parameter int REFRESH_PERIOD = 1024,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hbm_req_valid,
    output logic                  hbm_req_ready,
    input  logic [ADDR_WIDTH-1:0] hbm_addr,
    input  logic                  hbm_wr_en,
    input  logic [DATA_WIDTH-1:0] hbm_wr_data,
    output logic                  hbm_rd_valid,
    output logic [DATA_WIDTH-1:0] hbm_rd_data,
    output logic                  hbm_err,
    output logic                  refresh_active
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic                  accept;
    logic                  in_range;
    logic [IDX_W-1:0]      word_idx;
    logic                  wr_err_q;
    logic                  pipe_err;
    logic                  unused_addr_lsbs;

    assign accept           = hbm_req_valid && hbm_req_ready;
    assign word_idx         = hbm_addr[HBM_WORD_LSB +: IDX_W];
    assign in_range         = ADDR_WIDTH'(hbm_addr[ADDR_WIDTH-1:HBM_WORD_LSB]) < ADDR_WIDTH'(DEPTH_WORDS);
    assign unused_addr_lsbs = ^hbm_addr[HBM_WORD_LSB-1:0];

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (accept && hbm_wr_en && in_range) begin
            mem[word_idx] <= hbm_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= accept && hbm_wr_en && !in_range;
        end
    end

    hbm_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept && !hbm_wr_en),
        .in_data   (mem[word_idx]),
        .in_err    (!in_range),
        .out_valid (hbm_rd_valid),
        .out_data  (hbm_rd_data),
        .out_err   (pipe_err)
    );

    assign hbm_err = pipe_err || wr_err_q;

`ifdef HBM_RESP_REFRESH_EN
    localparam int CNT_W = $clog2(REFRESH_PERIOD + 1);
    localparam int TMR_W = $clog2(REFRESH_CYCLES + 1);

    hbm_resp_state_t  state_q, state_d;
    logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [TMR_W-1:0] stall_tmr_q, stall_tmr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ACTIVE;
            refresh_cnt_q <= '0;
            stall_tmr_q   <= '0;
        end else begin
            state_q       <= state_d;
            refresh_cnt_q <= refresh_cnt_d;
            stall_tmr_q   <= stall_tmr_d;
        end
    end

    // Stall length is a down-counter loaded on entry; exit on terminal count.
    always_comb begin
        state_d       = state_q;
        refresh_cnt_d = refresh_cnt_q;
        stall_tmr_d   = stall_tmr_q;
        case (state_q)
            ACTIVE: begin
                if (refresh_cnt_q == CNT_W'(REFRESH_PERIOD - 1)) begin
                    state_d       = REFRESH;
                    refresh_cnt_d = '0;
                    stall_tmr_d   = TMR_W'(REFRESH_CYCLES - 1);
                end else begin
                    refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
                end
            end
            REFRESH: begin
                if (stall_tmr_q == '0) begin
                    state_d = ACTIVE;
                end else begin
                    stall_tmr_d = stall_tmr_q - TMR_W'(1);
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    assign hbm_req_ready  = (state_q == ACTIVE);
    assign refresh_active = (state_q == REFRESH);
`else
    assign hbm_req_ready  = !rst;
    assign refresh_active = 1'b0;
`endif
endmodule

// File: doc/hbm_responder.md
HBM_RESPONDER -- requirements
Module: hbm_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, meaning bits per HBM word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-003 SHALL have parameter DEPTH_WORDS, default 256 (power of 2), meaning storage words.
REQ-004 SHALL have parameter RD_LATENCY, default 2 (legal range 1..8), meaning accept-to-read-data cycles.
REQ-005 SHALL have parameters REFRESH_PERIOD, default 1024, and REFRESH_CYCLES, default 8, meaning active cycles between refreshes and stall length.
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- hbm_req_valid  in  1  initiator request valid.
- hbm_req_ready  out  1  responder can accept.
- hbm_addr  in  ADDR_WIDTH  byte address.
- hbm_wr_en  in  1  1 = write, 0 = read.
- hbm_wr_data  in  DATA_WIDTH  write data.
- hbm_rd_valid  out  1  read data valid, single-cycle pulse.
- hbm_rd_data  out  DATA_WIDTH  read data.
- hbm_err  out  1  out-of-range access pulse.
- refresh_active  out  1  high while in REFRESH.

Function
REQ-008 SHALL accept a request in a cycle where hbm_req_valid and hbm_req_ready are both high; at most one request per cycle.
REQ-009 SHALL index storage by word = hbm_addr[6 +: log2(DEPTH_WORDS)]; addr[5:0] ignored.
REQ-010 SHALL treat any request with hbm_addr[ADDR_WIDTH-1:6] >= DEPTH_WORDS as out of range.
REQ-011 SHALL write an accepted in-range write into storage at the accept edge; the write is visible to any read accepted in a later cycle.
REQ-012 SHALL drop an out-of-range write and pulse hbm_err in the cycle after accept.
REQ-013 SHALL, for a read accepted in cycle N, assert hbm_rd_valid for exactly cycle N+RD_LATENCY with the word content as of cycle N; for out-of-range reads, return all-zero data with hbm_err high in that same cycle.
REQ-014 SHALL sustain one read per cycle; there is no rd_ready, and responses are never stalled or reordered.
REQ-015 SHALL hold hbm_rd_data at 0 whenever hbm_rd_valid is low.
REQ-016 SHALL implement FSM states ACTIVE and REFRESH; hbm_req_ready = (state == ACTIVE).
REQ-017 SHALL, in ACTIVE, increment refresh_cnt each cycle; at refresh_cnt == REFRESH_PERIOD-1 it SHALL go to REFRESH and clear refresh_cnt. A request handshaken in that same cycle is accepted.
REQ-018 SHALL, in REFRESH, hold ready low for exactly REFRESH_CYCLES cycles, then return to ACTIVE; refresh_active = (state == REFRESH).
REQ-019 SHALL let in-flight read responses complete normally during REFRESH.

Reset
REQ-020 SHALL, on rst, set state ACTIVE, refresh_cnt 0, and all read-pipe valids 0; outputs SHALL be hbm_req_ready 1, hbm_rd_valid 0, hbm_rd_data 0, hbm_err 0, refresh_active 0.
REQ-021 SHALL discard reads in flight when rst is asserted; no hbm_rd_valid from them after reset.
REQ-022 SHALL NOT clear storage contents on reset.

Configuration
REQ-023 SHALL use macro HBM_RESP_REFRESH_EN. When defined: REQ-016..019 apply. When undefined: no FSM or refresh counter, hbm_req_ready tied to !rst, and refresh_active tied 0.

Structure
REQ-024 SHALL place HBM_DATA_WIDTH, HBM_ADDR_WIDTH, HBM_WORD_LSB (=6) and typedef hbm_resp_state_t {ACTIVE, REFRESH} in shared package hbm_pkg.
REQ-025 SHALL implement the read-latency delay line (valid, data, err) as sub-module hbm_rd_pipe, parameterised by RD_LATENCY.

Verification
REQ-026 Write 0xA5..A5 to addr 0x40, then read addr 0x40 -> hbm_rd_valid 2 cycles after accept, data 0xA5..A5, hbm_err 0.
REQ-027 Back-to-back reads of addrs 0x0, 0x40, 0x80 on consecutive cycles -> three consecutive rd_valid pulses in order, with the previously written data.
REQ-028 Read at addr 0x4000 (word 256, DEPTH_WORDS 256) -> rd_valid with data 0 and hbm_err 1 in the same cycle; write at 0x4000 -> hbm_err pulse, storage unchanged.
REQ-029 REFRESH_PERIOD 16, REFRESH_CYCLES 4, requests held valid -> ready low for exactly 4 cycles after 16 active cycles; the request in cycle 16 is accepted; none are lost.
REQ-030 Read accepted, rst asserted next cycle -> no hbm_rd_valid afterwards; state ACTIVE, ready 1.
REQ-031 Build without HBM_RESP_REFRESH_EN, stream 2000 requests -> ready never drops and refresh_active stays 0.
